// File: rtl/decoder_5to32_reg.sv
// -----------------------------------------------------------------------------
// decoder_5to32_reg
//
// Registered 5-to-32 one-hot decoder with enable. Turns a 5-bit register index
// into 32 individual select / write-enable lines, one per register-file entry.
// The result is captured in flops so downstream write-enable logic only ever
// sees clean, glitch-free selects.
//
// Ports:
//   CLK    in   1   system clock, rising-edge triggered
//   RST_N  in   1   asynchronous active-low reset, clears OUT immediately
//   IN     in   5   binary select index, 0..31 (every code is valid)
//   EN     in   1   decode enable, active-high; EN=0 decodes to all-zero
//   OUT    out  32  registered one-hot select, bit k set means IN==k decoded
//
// Timing: IN/EN sampled at edge n appear on OUT right after edge n. OUT comes
// straight from flops; there is no combinational path from IN or EN to OUT.
//
// decoder_5to32_reg_chk is a property checker for the one-hot invariant. It is
// bound by the environment, not instantiated in the datapath.
// -----------------------------------------------------------------------------
module decoder_5to32_reg (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [4:0]  IN,
    input  logic        EN,
    output logic [31:0] OUT
);

    // Binary index to one-hot word. The index range exactly covers the
    // 32 output bits, so there is no out-of-range code to guard against.
    function automatic logic [31:0] onehot_decode(input logic [4:0] idx);
        logic [31:0] word;
        word = 32'h0000_0001 << idx;
        return word;
    endfunction

    logic [31:0] dec_s;
    logic [31:0] out_r;

    // Next select word: one-hot of IN when enabled, all-zero otherwise.
    always_comb begin
        dec_s = 32'h0000_0000;
        if (EN) begin
            dec_s = onehot_decode(IN);
        end else begin
            dec_s = 32'h0000_0000;
        end
    end

    // Select register: async clear, otherwise capture the decoded word.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_r <= 32'h0000_0000;
        end else begin
            out_r <= dec_s;
        end
    end

    assign OUT = out_r;

endmodule

// -----------------------------------------------------------------------------
// decoder_5to32_reg_chk
//
// Property checker for decoder_5to32_reg: outside reset, OUT has at most one
// bit set and carries no unknown bits.
//
// Ports:
//   CLK    in   1   same clock as the decoder
//   RST_N  in   1   same reset as the decoder; properties are off while low
//   OUT    in   32  decoder output being watched
// -----------------------------------------------------------------------------
module decoder_5to32_reg_chk (
    input logic        CLK,
    input logic        RST_N,
    input logic [31:0] OUT
);

    // Outside reset the select word is zero or one-hot.
    a_onehot0: assert property (@(posedge CLK) disable iff (!RST_N) $onehot0(OUT))
        else $error("decoder_5to32_reg_chk: OUT not one-hot-or-zero: %h", OUT);

    // Outside reset the select word never carries unknown bits.
    a_known: assert property (@(posedge CLK) disable iff (!RST_N) !$isunknown(OUT))
        else $error("decoder_5to32_reg_chk: OUT has unknown bits: %h", OUT);

endmodule

// File: tb/tb_decoder_5to32_reg.sv
// -----------------------------------------------------------------------------
// tb_decoder_5to32_reg
//
// Self-checking bench for decoder_5to32_reg. A table of directed vectors
// {en, in, expected out} is applied one per clock. Hand-written sequences
// cover reset, asynchronous mid-run reset, latency, and a full 0..31 sweep.
// Inputs change 1 ns after a rising edge. Outputs are checked away from the
// rising edge.
// -----------------------------------------------------------------------------
module tb_decoder_5to32_reg;

    logic        clk;
    logic        rst_n;
    logic [4:0]  in_s;
    logic        en_s;
    logic [31:0] out_s;

    int checks;
    int errors;

    typedef struct {
        logic        en;
        logic [4:0]  idx;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [0:15];

    decoder_5to32_reg dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .IN    (in_s),
        .EN    (en_s),
        .OUT   (out_s)
    );

    decoder_5to32_reg_chk chk (
        .CLK   (clk),
        .RST_N (rst_n),
        .OUT   (out_s)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Move to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] mask;
        checks = 0;
        errors = 0;

        // Sequential decode 0..6, enable gating on 12, repeated index,
        // and both boundaries.
        vecs[0]  = '{1'b1, 5'd0,  32'h0000_0001};
        vecs[1]  = '{1'b1, 5'd1,  32'h0000_0002};
        vecs[2]  = '{1'b1, 5'd2,  32'h0000_0004};
        vecs[3]  = '{1'b1, 5'd3,  32'h0000_0008};
        vecs[4]  = '{1'b1, 5'd4,  32'h0000_0010};
        vecs[5]  = '{1'b1, 5'd5,  32'h0000_0020};
        vecs[6]  = '{1'b1, 5'd6,  32'h0000_0040};
        vecs[7]  = '{1'b1, 5'd12, 32'h0000_1000};
        vecs[8]  = '{1'b0, 5'd12, 32'h0000_0000};
        vecs[9]  = '{1'b1, 5'd12, 32'h0000_1000};
        vecs[10] = '{1'b1, 5'd31, 32'h8000_0000};
        vecs[11] = '{1'b1, 5'd31, 32'h8000_0000};
        vecs[12] = '{1'b1, 5'd0,  32'h0000_0001};
        vecs[13] = '{1'b0, 5'd31, 32'h0000_0000};
        vecs[14] = '{1'b1, 5'd17, 32'h0002_0000};
        vecs[15] = '{1'b1, 5'd10, 32'h0000_0400};

        // Reset held: clock runs with a valid decode request, OUT stays zero.
        rst_n = 1'b0;
        en_s  = 1'b1;
        in_s  = 5'd7;
        #2;
        check("reset_immediate", out_s, 32'h0000_0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_hold", out_s, 32'h0000_0000);
        end
        rst_n = 1'b1;
        step();
        check("reset_release", out_s, 32'h0000_0080);

        // Directed table, one vector per cycle.
        for (int i = 0; i < 16; i++) begin
            en_s = vecs[i].en;
            in_s = vecs[i].idx;
            step();
            check($sformatf("vec%0d", i), out_s, vecs[i].exp);
        end

        // Full sweep with a walking mask and a one-hot check each cycle.
        mask = 32'h0000_0001;
        en_s = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_s = 5'(i);
            step();
            check($sformatf("sweep%0d", i), out_s, mask);
            check($sformatf("sweep%0d_ones", i), 32'($countones(out_s)), 32'd1);
            mask = {mask[30:0], 1'b0};
        end

        // Asynchronous reset in the middle of the clock period.
        en_s = 1'b1;
        in_s = 5'd20;
        step();
        check("pre_async", out_s, 32'h0010_0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", out_s, 32'h0000_0000);
        #1;
        rst_n = 1'b1;
        #1;
        check("async_before_edge", out_s, 32'h0000_0000);
        step();
        check("async_release", out_s, 32'h0010_0000);

        // Latency: change IN just after an edge, OUT holds until the next edge.
        in_s = 5'd3;
        step();
        check("lat_start", out_s, 32'h0000_0008);
        in_s = 5'd9;
        #3;
        check("lat_hold", out_s, 32'h0000_0008);
        step();
        check("lat_update", out_s, 32'h0000_0200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decoder_5to32_reg.md
Name: decoder_5to32_reg

Overview:
- Registered 5-to-32 one-hot decoder with an enable input.
- Used in the datapath to turn a 5-bit register index into 32 individual select/write-enable lines, one per register-file entry.
- The output is captured on the clock edge so downstream write-enable logic sees glitch-free selects.

Parameters:
- None. All widths are fixed: 5-bit index, 32-bit one-hot output.

Ports:
- CLK  input  1  system clock; rising-edge triggered.
- RST_N  input  1  asynchronous, active-low reset; clears OUT.
- IN  input  5  binary select index, 0..31.
- EN  input  1  decode enable, active-high.
- OUT  output  32  registered one-hot select; bit k set means IN==k was decoded.

Behaviour:
- One clock domain (CLK). Reset is asynchronous and active-low (RST_N); this polarity and synchronicity are fixed.
- Reset:
  - RST_N low forces OUT = 32'h0000_0000 immediately, without waiting for a CLK edge.
  - OUT holds zero while RST_N stays low, regardless of CLK, IN and EN.
  - Release of RST_N takes effect at the next CLK rising edge; no special synchronisation is required inside the block.
- Normal operation, on each CLK rising edge with RST_N high:
  - EN=1: OUT <= 32'b1 << IN. Exactly one bit is set, at position IN.
  - EN=0: OUT <= 32'h0000_0000.
- Latency: exactly 1 cycle from IN/EN sampled at edge n to OUT valid after edge n.
- OUT is driven directly by flops; no combinational path from IN or EN to OUT.
- Invariants:
  - $countones(OUT) is 0 or 1 at all times.
  - OUT is never X once reset has been applied.
- Boundary values:
  - IN=0 -> bit 0 (32'h0000_0001).
  - IN=31 -> bit 31 (32'h8000_0000).
  - All 32 codes are valid; there is no out-of-range case.
- Same IN on consecutive cycles: OUT stays stable and does not toggle.
- EN dropping mid-sequence: OUT is zero after the next edge. EN rising again resumes decoding at the next edge.
- Reset asserted mid-operation: OUT clears asynchronously. The first decode after release uses the IN/EN sampled at the first edge with RST_N high.
- X on IN while EN=1 is a don't-care for synthesis. Benches must not drive it.

Test Plan:
- Reset check: hold RST_N=0, toggle CLK with EN=1, IN=5'd7 -> OUT=32'h0000_0000 throughout. Release RST_N -> OUT=32'h0000_0080 after the first edge.
- Sequential decode: EN=1, step IN through 0,1,2,3,4,5,6, one value per cycle -> OUT is 32'h1, 32'h2, 32'h4, 32'h8, 32'h10, 32'h20, 32'h40, each exactly one cycle after its IN.
- Full sweep and boundaries: EN=1, IN=0..31 -> OUT == 1<<IN each cycle; specifically IN=31 -> 32'h8000_0000. Check one-hot property every cycle.
- Enable gating: EN=1, IN=5'd12 -> 32'h0000_1000. Then EN=0 with IN held -> 32'h0000_0000 next cycle. Then EN=1 -> 32'h0000_1000 again.
- Asynchronous reset mid-operation: EN=1, IN=5'd20, OUT=32'h0010_0000; pull RST_N low between clock edges -> OUT=0 before the next edge. Release -> 32'h0010_0000 after the next edge.
- Latency check: change IN from 3 to 9 just after an edge -> OUT stays 32'h0000_0008 until the next rising edge, then becomes 32'h0000_0200.
